// File: rtl/cpu_multi_pkg.sv
// Shared opcode, phase and field definitions for the cpu_multi sequencer.
// Opcodes 10/11 are only decoded when CPU_LOOP_EN is defined.
package lib_cpu_multi;

  localparam int MAX_IRQ = 16;
  localparam int IDX_W   = 4;

  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 3;
  localparam int CH_LSB  = 4;
  localparam int CH_MSB  = 7;
  localparam int IMM_LSB = 16;
  localparam int IMM_MSB = 31;

  typedef enum logic [3:0] {
    OP_JMP     = 4'd0,
    OP_LDI     = 4'd1,
    OP_SEND    = 4'd2,
    OP_HALT    = 4'd3,
    OP_LDRX    = 4'd4,
    OP_SETVEC  = 4'd5,
    OP_IEN     = 4'd6,
    OP_ACK     = 4'd7,
    OP_IRET    = 4'd8,
    OP_SETMASK = 4'd9,
    OP_LDC     = 4'd10,
    OP_DJNZ    = 4'd11
  } opcode_t;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

endpackage

// File: rtl/cpu_multi_irq_prio.sv
// Masked priority encoder: the lowest-index request that is both raised and
// unmasked wins.
module irq_prio
  import lib_cpu_multi::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] irr_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_IRQ-1:0] pending;

  assign pending = irr_i & mask_i;
  assign valid_o = |pending;

  // Scanning downwards lets the lowest set bit overwrite all higher ones.
  always_comb begin
    idx_o = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pending[k]) idx_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/cpu_multi.sv
// Two-phase instruction sequencer driving the UART TX path with prioritised,
// maskable interrupts. Define CPU_LOOP_EN to build the hardware loop counter.
module cpu_multi
  import lib_cpu_multi::*;
#(
  parameter int ADDR_W  = 11,
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [31:0]        rom_data,
  input  logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] ack,
  input  logic [7:0]         rx_data,
  output logic               tx_req,
  output logic [7:0]         tx_data,
  input  logic               tx_busy
);

  typedef struct packed {
    logic [ADDR_W-1:0]               pc;
    logic [7:0]                      tx_data;
    logic                            tx_req;
    logic [NUM_IRQ-1:0]              ack;
    logic                            intr_en;
    logic [NUM_IRQ-1:0]              mask;
    logic [NUM_IRQ-1:0][ADDR_W-1:0]  vec;
    logic [ADDR_W-1:0]               intr_pc;
`ifdef CPU_LOOP_EN
    logic [15:0]                     cnt;
`endif
  } state_t;

  state_t      state_q;
  state_t      state_d;
  phase_t      phase_q;

  opcode_t     op;
  logic [3:0]  ch;
  logic [15:0] imm;
  logic        irq_valid;
  logic [IDX_W-1:0]  irq_idx;
  logic [ADDR_W-1:0] vec_sel;
  logic        unused_rom;

  assign op  = opcode_t'(rom_data[OP_MSB:OP_LSB]);
  assign ch  = rom_data[CH_MSB:CH_LSB];
  assign imm = rom_data[IMM_MSB:IMM_LSB];
  assign unused_rom = ^rom_data[15:8];

`ifdef CPU_LOOP_EN
  logic [15:0] cnt_dec;
  assign cnt_dec = state_q.cnt - 16'd1;
`endif

  irq_prio #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq_prio (
    .irr_i  (irr),
    .mask_i (state_q.mask),
    .valid_o(irq_valid),
    .idx_o  (irq_idx)
  );

  always_comb begin
    vec_sel = state_q.vec[0];
    for (int k = 1; k < NUM_IRQ; k++) begin
      if (irq_idx == IDX_W'(k)) vec_sel = state_q.vec[k];
    end
  end

  always_comb begin
    state_d        = state_q;
    state_d.pc     = state_q.pc + 1'b1;
    state_d.tx_req = 1'b0;
    state_d.ack    = '0;
    // Interrupt entry pre-empts decode; the fetched word is dropped entirely.
    if (state_q.intr_en && irq_valid) begin
      state_d.pc      = vec_sel;
      state_d.intr_pc = state_q.pc;
      state_d.intr_en = 1'b0;
    end else begin
      case (op)
        OP_JMP:  state_d.pc = ADDR_W'(imm);
        OP_LDI:  state_d.tx_data = imm[7:0];
        OP_SEND: begin
          if (tx_busy) state_d.pc = state_q.pc;
          else         state_d.tx_req = 1'b1;
        end
        OP_HALT: state_d.pc = state_q.pc;
        OP_LDRX: state_d.tx_data = rx_data;
        OP_SETVEC: begin
          for (int k = 0; k < NUM_IRQ; k++) begin
            if (ch == 4'(k)) state_d.vec[k] = ADDR_W'(imm);
          end
        end
        OP_IEN: state_d.intr_en = imm[0];
        OP_ACK: begin
          for (int k = 0; k < NUM_IRQ; k++) begin
            if (ch == 4'(k)) state_d.ack[k] = 1'b1;
          end
        end
        OP_IRET: begin
          state_d.pc      = state_q.intr_pc;
          state_d.intr_en = 1'b1;
        end
        OP_SETMASK: state_d.mask = NUM_IRQ'(imm);
`ifdef CPU_LOOP_EN
        OP_LDC: state_d.cnt = imm;
        OP_DJNZ: begin
          state_d.cnt = cnt_dec;
          if (cnt_dec != 16'd0) state_d.pc = ADDR_W'(imm);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_FETCH;
      state_q <= '0;
    end else begin
      phase_q <= (phase_q == PH_FETCH) ? PH_EXEC : PH_FETCH;
      if (phase_q == PH_EXEC) state_q <= state_d;
    end
  end

  assign rom_addr = state_q.pc;
  assign tx_req   = state_q.tx_req;
  assign tx_data  = state_q.tx_data;
  assign ack      = state_q.ack;

endmodule
